// File: rtl/rf_wb_if.sv
// Writeback bus between the dual-issue pipeline and the register-file writeback scheduler.
// The scheduler has no ready signals: it accepts every valid writeback every cycle.
interface rf_wb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NREGS      = 32
);
  localparam int AW = $clog2(NREGS);

  logic                  flush_i;
  logic                  iss1_valid_i;
  logic                  iss2_valid_i;
  logic [AW-1:0]         iss1_rd_i;
  logic [AW-1:0]         iss2_rd_i;
  logic                  wb11_valid_i;
  logic                  wb12_valid_i;
  logic                  wb21_valid_i;
  logic                  wb22_valid_i;
  logic [AW-1:0]         wb11_rd_i;
  logic [AW-1:0]         wb12_rd_i;
  logic [AW-1:0]         wb21_rd_i;
  logic [AW-1:0]         wb22_rd_i;
  logic [DATA_WIDTH-1:0] wb11_data_i;
  logic [DATA_WIDTH-1:0] wb12_data_i;
  logic [DATA_WIDTH-1:0] wb21_data_i;
  logic [DATA_WIDTH-1:0] wb22_data_i;

  logic [NREGS-1:0]      we11_o;
  logic [NREGS-1:0]      we12_o;
  logic [NREGS-1:0]      we21_o;
  logic [NREGS-1:0]      we22_o;
  logic [DATA_WIDTH-1:0] wdata11_o;
  logic [DATA_WIDTH-1:0] wdata12_o;
  logic [DATA_WIDTH-1:0] wdata21_o;
  logic [DATA_WIDTH-1:0] wdata22_o;
  logic [NREGS-1:0]      pending_o;
  logic [NREGS-1:0]      full_o;
  logic                  err_o;

  modport slave (
    input  flush_i, iss1_valid_i, iss2_valid_i, iss1_rd_i, iss2_rd_i,
    input  wb11_valid_i, wb12_valid_i, wb21_valid_i, wb22_valid_i,
    input  wb11_rd_i, wb12_rd_i, wb21_rd_i, wb22_rd_i,
    input  wb11_data_i, wb12_data_i, wb21_data_i, wb22_data_i,
    output we11_o, we12_o, we21_o, we22_o,
    output wdata11_o, wdata12_o, wdata21_o, wdata22_o,
    output pending_o, full_o, err_o
  );

  modport master (
    output flush_i, iss1_valid_i, iss2_valid_i, iss1_rd_i, iss2_rd_i,
    output wb11_valid_i, wb12_valid_i, wb21_valid_i, wb22_valid_i,
    output wb11_rd_i, wb12_rd_i, wb21_rd_i, wb22_rd_i,
    output wb11_data_i, wb12_data_i, wb21_data_i, wb22_data_i,
    input  we11_o, we12_o, we21_o, we22_o,
    input  wdata11_o, wdata12_o, wdata21_o, wdata22_o,
    input  pending_o, full_o, err_o
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler: squashes older same-destination writes, registers one-hot write
// enables for the 2R/4W register cells, and tracks in-flight writes per register.
module rf_wb_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NREGS      = 32
) (
  input  logic    clk,
  input  logic    rst,
  rf_wb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [NREGS-1:0] ONE_HOT_0 = NREGS'(1);

  // Port index order is program order: 0=lane1 ALU (oldest) .. 3=lane2 MEM (youngest).
  logic                  wb_v  [4];
  logic [AW-1:0]         wb_rd [4];
  logic [DATA_WIDTH-1:0] wb_d  [4];

  assign wb_v[0]  = bus.wb11_valid_i;
  assign wb_v[1]  = bus.wb12_valid_i;
  assign wb_v[2]  = bus.wb21_valid_i;
  assign wb_v[3]  = bus.wb22_valid_i;
  assign wb_rd[0] = bus.wb11_rd_i;
  assign wb_rd[1] = bus.wb12_rd_i;
  assign wb_rd[2] = bus.wb21_rd_i;
  assign wb_rd[3] = bus.wb22_rd_i;
  assign wb_d[0]  = bus.wb11_data_i;
  assign wb_d[1]  = bus.wb12_data_i;
  assign wb_d[2]  = bus.wb21_data_i;
  assign wb_d[3]  = bus.wb22_data_i;

  // A write survives only if no younger valid write targets the same register; the
  // cell's fixed port priority would otherwise let the oldest value win.
  logic [3:0] eff;

  always_comb begin
    eff = '0;
    for (int p = 0; p < 4; p++) begin
      eff[p] = wb_v[p] && (wb_rd[p] != '0);
      for (int q = p + 1; q < 4; q++) begin
        if (wb_v[q] && (wb_rd[q] == wb_rd[p])) eff[p] = 1'b0;
      end
    end
  end

  logic [NREGS-1:0]      we_q    [4];
  logic [DATA_WIDTH-1:0] wdata_q [4];

  always_ff @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (!rst) begin
        we_q[p]    <= '0;
        wdata_q[p] <= '0;
      end else if (eff[p] && !bus.flush_i) begin
        we_q[p]    <= ONE_HOT_0 << wb_rd[p];
        wdata_q[p] <= wb_d[p];
      end else begin
        we_q[p]    <= '0;
        wdata_q[p] <= '0;
      end
    end
  end

  assign bus.we11_o    = we_q[0];
  assign bus.we12_o    = we_q[1];
  assign bus.we21_o    = we_q[2];
  assign bus.we22_o    = we_q[3];
  assign bus.wdata11_o = wdata_q[0];
  assign bus.wdata12_o = wdata_q[1];
  assign bus.wdata21_o = wdata_q[2];
  assign bus.wdata22_o = wdata_q[3];

  // In-flight scoreboard. Squashed writebacks still retire their issue, so every
  // valid writeback decrements regardless of effectiveness.
  logic [1:0]        cnt     [NREGS];
  logic [1:0]        cnt_nxt [NREGS];
  logic signed [3:0] sum     [NREGS];
  logic [NREGS-1:0]  bound_hit;
  logic [NREGS-1:0]  pending_q;
  logic [NREGS-1:0]  full_q;
  logic              err_q;

  always_comb begin
    bound_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      sum[r]     = $signed({2'b00, cnt[r]});
      cnt_nxt[r] = '0;
      if (r != 0) begin
        if (bus.iss1_valid_i && (bus.iss1_rd_i == AW'(r))) sum[r] = sum[r] + 4'sd1;
        if (bus.iss2_valid_i && (bus.iss2_rd_i == AW'(r))) sum[r] = sum[r] + 4'sd1;
        for (int p = 0; p < 4; p++) begin
          if (wb_v[p] && (wb_rd[p] == AW'(r))) sum[r] = sum[r] - 4'sd1;
        end
        if (sum[r] > 4'sd3) begin
          cnt_nxt[r]   = 2'd3;
          bound_hit[r] = 1'b1;
        end else if (sum[r] < 4'sd0) begin
          cnt_nxt[r]   = 2'd0;
          bound_hit[r] = 1'b1;
        end else begin
          cnt_nxt[r] = sum[r][1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      pending_q <= '0;
      full_q    <= '0;
      err_q     <= 1'b0;
    end else if (bus.flush_i) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
      pending_q <= '0;
      full_q    <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt[r]       <= cnt_nxt[r];
        pending_q[r] <= (cnt_nxt[r] != 2'd0);
        full_q[r]    <= (cnt_nxt[r] == 2'd3);
      end
      err_q <= err_q | (|bound_hit);
    end
  end

  assign bus.pending_o = pending_q;
  assign bus.full_o    = full_q;
  assign bus.err_o     = err_q;
endmodule
